// File: rtl/seg_display_arbiter_if.sv
// rtl/seg_display_arbiter_if.sv - request/value inputs and display outputs of the display arbiter
interface seg_display_arbiter_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]    req_in;
  logic [14*N_REQ-1:0] val_in;
  logic [N_REQ-1:0]    grant_out;
  logic [15:0]         bcd_out;
  logic                bcd_valid;
  logic                busy_out;

  // Value sources drive requests and observe the display state
  modport master (
    output req_in, val_in,
    input  grant_out, bcd_out, bcd_valid, busy_out
  );

  // The arbiter consumes requests and owns the display outputs
  modport slave (
    input  req_in, val_in,
    output grant_out, bcd_out, bcd_valid, busy_out
  );
endinterface

// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin display sharing with iterative binary-to-BCD conversion
module seg_display_arbiter #(
  parameter int N_REQ       = 3,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  seg_display_arbiter_if.slave bus
);

  localparam int              IDX_W     = $clog2(N_REQ);
  localparam int              HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);
  localparam logic [13:0]     BCD_MAX   = 14'd9999;
  localparam logic [3:0]      LAST_ITER = 4'd13;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [N_REQ-1:0] grant_q,     grant_d;
  logic [15:0]      bcd_out_q,   bcd_out_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             busy_q,      busy_d;
  logic [IDX_W-1:0] ptr_q,       ptr_d;
  logic [IDX_W-1:0] own_idx_q,   own_idx_d;
  logic [13:0]      latched_q,   latched_d;
  logic [13:0]      bin_q,       bin_d;
  logic [15:0]      acc_q,       acc_d;
  logic [3:0]       iter_q,      iter_d;
  logic [HC_W-1:0]  hold_q,      hold_d;

  // Values above four decimal digits are clamped so the display never overflows
  function automatic logic [13:0] sat14(input logic [13:0] v);
    return (v > BCD_MAX) ? BCD_MAX : v;
  endfunction

  // Round-robin search: first asserted request starting at the pointer, wrapping
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (int'(ptr_q) + k >= N_REQ) begin
        cand = IDX_W'(int'(ptr_q) + k - N_REQ);
      end else begin
        cand = IDX_W'(int'(ptr_q) + k);
      end
      if (!win_found && bus.req_in[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Select the candidate winner's value and the current owner's request/value
  logic [13:0] win_val;
  logic [13:0] own_val;
  logic        own_req;
  always_comb begin
    win_val = '0;
    own_val = '0;
    own_req = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) begin
        win_val = bus.val_in[14*i +: 14];
      end
      if (own_idx_q == IDX_W'(i)) begin
        own_val = bus.val_in[14*i +: 14];
        own_req = bus.req_in[i];
      end
    end
  end

  logic [13:0] own_sat;
  logic        own_changed;
  assign own_sat     = sat14(own_val);
  assign own_changed = (own_sat != latched_q);

  // One double-dabble iteration: correct nibbles >= 5, then shift {bcd,bin} left
  logic [15:0] adj;
  logic [29:0] shifted;
  logic [15:0] bcd_step;
  logic [13:0] bin_step;
  always_comb begin
    adj = acc_q;
    for (int n = 0; n < 4; n++) begin
      if (adj[4*n +: 4] >= 4'd5) begin
        adj[4*n +: 4] = adj[4*n +: 4] + 4'd3;
      end
    end
    shifted  = {adj, bin_q} << 1;
    bcd_step = shifted[29:14];
    bin_step = shifted[13:0];
  end

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: grant from IDLE, 14 iterations in CONVERT, release or reconvert from HOLD
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) state_d = S_CONVERT;
      end
      S_CONVERT: begin
        if (iter_q == LAST_ITER) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!own_req) begin
          state_d = S_IDLE;
        end else if (own_changed) begin
          state_d = S_CONVERT;
        end else if (hold_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values for each state
  always_comb begin
    grant_d     = grant_q;
    bcd_out_d   = bcd_out_q;
    bcd_valid_d = 1'b0;
    busy_d      = 1'b0;
    ptr_d       = ptr_q;
    own_idx_d   = own_idx_q;
    latched_d   = latched_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    iter_d      = iter_q;
    hold_d      = hold_q;
    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (win_found) begin
          grant_d   = N_REQ'(1) << win_idx;
          own_idx_d = win_idx;
          latched_d = sat14(win_val);
          bin_d     = sat14(win_val);
          acc_d     = '0;
          iter_d    = '0;
          busy_d    = 1'b1;
          ptr_d     = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      S_CONVERT: begin
        bin_d  = bin_step;
        acc_d  = bcd_step;
        iter_d = iter_q + 4'd1;
        busy_d = 1'b1;
        if (iter_q == LAST_ITER) begin
          bcd_out_d   = bcd_step;
          bcd_valid_d = 1'b1;
          hold_d      = HOLD_LOAD;
          busy_d      = 1'b0;
        end
      end
      S_HOLD: begin
        if (!own_req) begin
          grant_d = '0;
        end else if (own_changed) begin
          latched_d = own_sat;
          bin_d     = own_sat;
          acc_d     = '0;
          iter_d    = '0;
          busy_d    = 1'b1;
        end else if (hold_q == '0) begin
          grant_d = '0;
        end else begin
          hold_d = hold_q - HC_W'(1);
        end
      end
      default: begin
        grant_d = '0;
      end
    endcase
  end

  // Output and datapath registers; reset aborts any conversion and blanks the display
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_q     <= '0;
      bcd_out_q   <= '0;
      bcd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      ptr_q       <= '0;
      own_idx_q   <= '0;
      latched_q   <= '0;
      bin_q       <= '0;
      acc_q       <= '0;
      iter_q      <= '0;
      hold_q      <= '0;
    end else begin
      grant_q     <= grant_d;
      bcd_out_q   <= bcd_out_d;
      bcd_valid_q <= bcd_valid_d;
      busy_q      <= busy_d;
      ptr_q       <= ptr_d;
      own_idx_q   <= own_idx_d;
      latched_q   <= latched_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      iter_q      <= iter_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.grant_out = grant_q;
  assign bus.bcd_out   = bcd_out_q;
  assign bus.bcd_valid = bcd_valid_q;
  assign bus.busy_out  = busy_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// tb/tb_seg_display_arbiter.sv - directed self-checking bench for seg_display_arbiter
module tb_seg_display_arbiter;

  localparam int N_REQ       = 3;
  localparam int HOLD_CYCLES = 4;

  logic clk_in;
  logic rst_in;

  seg_display_arbiter_if #(.N_REQ(N_REQ)) bus ();

  seg_display_arbiter #(
    .N_REQ       (N_REQ),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_val(input int idx, input logic [13:0] v);
    bus.val_in[14*idx +: 14] = v;
  endtask

  task automatic do_reset;
    rst_in     = 1'b1;
    bus.req_in = '0;
    tick;
    tick;
    rst_in = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      tick;
      n++;
    end while (!bus.bcd_valid && n < 40);
  endtask

  task automatic test_reset;
    rst_in     = 1'b1;
    bus.req_in = 3'b111;
    set_val(0, 14'd1234);
    tick;
    tick;
    tests_run++;
    if (bus.grant_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_grant: got %b expected 000", bus.grant_out);
    end
    tests_run++;
    if (bus.bcd_out !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_bcd: got %h expected 0000", bus.bcd_out);
    end
    tests_run++;
    if (bus.bcd_valid !== 1'b0 || bus.busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got valid=%b busy=%b expected 0 0", bus.bcd_valid, bus.busy_out);
    end
    bus.req_in = '0;
    rst_in     = 1'b0;
    tick;
  endtask

  task automatic test_single;
    int n;
    set_val(0, 14'd1234);
    bus.req_in = 3'b001;
    tick;
    tests_run++;
    if (bus.grant_out !== 3'b001 || bus.busy_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant: got grant=%b busy=%b expected 001 1", bus.grant_out, bus.busy_out);
    end
    wait_valid(n);
    tests_run++;
    if (n !== 14) begin
      tests_failed++;
      $display("FAIL single_latency: got %0d expected 14", n);
    end
    tests_run++;
    if (bus.bcd_out !== 16'h1234) begin
      tests_failed++;
      $display("FAIL single_bcd: got %h expected 1234", bus.bcd_out);
    end
    tick;
    tests_run++;
    if (bus.bcd_valid !== 1'b0 || bus.grant_out !== 3'b001) begin
      tests_failed++;
      $display("FAIL single_pulse: got valid=%b grant=%b expected 0 001", bus.bcd_valid, bus.grant_out);
    end
    bus.req_in = '0;
    tick;
    tests_run++;
    if (bus.grant_out !== 3'b000 || bus.bcd_out !== 16'h1234) begin
      tests_failed++;
      $display("FAIL single_release: got grant=%b bcd=%h expected 000 1234", bus.grant_out, bus.bcd_out);
    end
  endtask

  task automatic test_round_robin;
    logic [2:0]  exp_g [4];
    logic [15:0] exp_b [4];
    int n;
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_b = '{16'h0111, 16'h0222, 16'h0333, 16'h0111};
    do_reset;
    set_val(0, 14'd111);
    set_val(1, 14'd222);
    set_val(2, 14'd333);
    bus.req_in = 3'b111;
    tick;
    for (int r = 0; r < 4; r++) begin
      tests_run++;
      if (bus.grant_out !== exp_g[r]) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", r, bus.grant_out, exp_g[r]);
      end
      wait_valid(n);
      tests_run++;
      if (n !== 14 || bus.bcd_out !== exp_b[r]) begin
        tests_failed++;
        $display("FAIL rr_bcd[%0d]: got lat=%0d bcd=%h expected 14 %h", r, n, bus.bcd_out, exp_b[r]);
      end
      n = 0;
      while (bus.grant_out !== 3'b000 && n < 20) begin
        tick;
        n++;
      end
      tests_run++;
      if (n !== HOLD_CYCLES) begin
        tests_failed++;
        $display("FAIL rr_hold[%0d]: got %0d expected %0d", r, n, HOLD_CYCLES);
      end
      tick;
    end
    bus.req_in = '0;
  endtask

  task automatic test_saturation;
    logic [13:0] vin  [5];
    logic [15:0] vexp [5];
    int n;
    vin  = '{14'd16383, 14'd0, 14'd10000, 14'd9999, 14'd1000};
    vexp = '{16'h9999, 16'h0000, 16'h9999, 16'h9999, 16'h1000};
    do_reset;
    for (int k = 0; k < 5; k++) begin
      set_val(0, vin[k]);
      bus.req_in = 3'b001;
      tick;
      wait_valid(n);
      tests_run++;
      if (n !== 14 || bus.bcd_out !== vexp[k]) begin
        tests_failed++;
        $display("FAIL sat[%0d]: got lat=%0d bcd=%h expected 14 %h", k, n, bus.bcd_out, vexp[k]);
      end
      bus.req_in = '0;
      tick;
    end
    set_val(0, 14'd9999);
    bus.req_in = 3'b001;
    tick;
    wait_valid(n);
    bus.req_in = '0;
    tick;
  endtask

  task automatic test_reset_mid_convert;
    int pulses;
    set_val(0, 14'd5678);
    bus.req_in = 3'b001;
    tick;
    for (int i = 0; i < 6; i++) tick;
    rst_in = 1'b1;
    tick;
    tests_run++;
    if (bus.grant_out !== 3'b000 || bus.bcd_out !== 16'h0000 || bus.busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_state: got grant=%b bcd=%h busy=%b expected 000 0000 0",
               bus.grant_out, bus.bcd_out, bus.busy_out);
    end
    rst_in     = 1'b0;
    bus.req_in = '0;
    pulses     = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (bus.bcd_valid === 1'b1) pulses++;
    end
    tests_run++;
    if (pulses !== 0) begin
      tests_failed++;
      $display("FAIL abort_pulse: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_early_release;
    int n;
    do_reset;
    set_val(0, 14'd42);
    set_val(2, 14'd77);
    bus.req_in = 3'b001;
    tick;
    wait_valid(n);
    bus.req_in = 3'b100;
    tick;
    tests_run++;
    if (bus.grant_out !== 3'b000) begin
      tests_failed++;
      $display("FAIL release_drop: got %b expected 000", bus.grant_out);
    end
    tick;
    tests_run++;
    if (bus.grant_out !== 3'b100) begin
      tests_failed++;
      $display("FAIL release_regrant: got %b expected 100", bus.grant_out);
    end
    wait_valid(n);
    tests_run++;
    if (n !== 14 || bus.bcd_out !== 16'h0077) begin
      tests_failed++;
      $display("FAIL release_bcd: got lat=%0d bcd=%h expected 14 0077", n, bus.bcd_out);
    end
    bus.req_in = '0;
    tick;
  endtask

  task automatic test_revalue;
    int n;
    do_reset;
    set_val(0, 14'd42);
    bus.req_in = 3'b001;
    tick;
    wait_valid(n);
    tests_run++;
    if (bus.bcd_out !== 16'h0042) begin
      tests_failed++;
      $display("FAIL revalue_first: got %h expected 0042", bus.bcd_out);
    end
    set_val(0, 14'd43);
    tick;
    tests_run++;
    if (bus.grant_out !== 3'b001 || bus.busy_out !== 1'b1 || bus.bcd_out !== 16'h0042) begin
      tests_failed++;
      $display("FAIL revalue_restart: got grant=%b busy=%b bcd=%h expected 001 1 0042",
               bus.grant_out, bus.busy_out, bus.bcd_out);
    end
    wait_valid(n);
    tests_run++;
    if (n !== 14 || bus.bcd_out !== 16'h0043 || bus.grant_out !== 3'b001) begin
      tests_failed++;
      $display("FAIL revalue_bcd: got lat=%0d bcd=%h grant=%b expected 14 0043 001",
               n, bus.bcd_out, bus.grant_out);
    end
    bus.req_in = '0;
    tick;
  endtask

  initial begin
    rst_in     = 1'b1;
    bus.req_in = '0;
    bus.val_in = '0;
    test_reset;
    test_single;
    test_round_robin;
    test_saturation;
    test_reset_mid_convert;
    test_early_release;
    test_revalue;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
